// File: rtl/flag_context_controller.sv
// Flag/CCR update arbiter with a LIFO of saved flag
// contexts for nested interrupt entry and RTI restore.
module flag_context_controller #(
  parameter int DEPTH        = 4,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       intReq,
  input  logic       rtiReq,
  input  logic       aluUpdate,
  input  logic [3:0] aluFlags,
  input  logic       setc,
  input  logic       clrc,
  input  logic [3:0] curFlags,
  output logic       updateStatus,
  output logic [1:0] carryFlag,
  output logic [3:0] newStatus,
  output logic [3:0] savedStatus,
  output logic       intAck,
  output logic       stall,
  output logic       busy,
  output logic       stackOverflow,
  output logic       stackUnderflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE, S_SAVE, S_FLUSH, S_RESTORE
  } state_t;

  state_t          r_state, w_state_n;
  logic [PW-1:0]   r_ptr, w_ptr_n;
  logic [2:0]      r_cnt, w_cnt_n;
  logic [3:0]      r_stack [DEPTH];
  logic            r_upd, w_upd_n;
  logic [1:0]      r_cf, w_cf_n;
  logic [3:0]      r_ns, w_ns_n;
  logic [3:0]      r_ss, w_ss_n;
  logic            r_ack, w_ack_n;
  logic            r_stall, w_stall_n;
  logic            r_busy, w_busy_n;
  logic            r_ovf, w_ovf_n;
  logic            r_unf, w_unf_n;
  logic            w_push;
  logic            w_full;
  logic [AW-1:0]   w_wr_idx;
  logic [AW-1:0]   w_rd_idx;

  assign w_full   = (r_ptr == PW'(DEPTH));
  assign w_wr_idx = r_ptr[AW-1:0];
  assign w_rd_idx = AW'(r_ptr - 1'b1);

  always_comb begin
    w_state_n = r_state;
    w_ptr_n   = r_ptr;
    w_cnt_n   = r_cnt;
    w_upd_n   = 1'b0;
    w_cf_n    = 2'b00;
    w_ns_n    = r_ns;
    w_ss_n    = r_ss;
    w_ack_n   = 1'b0;
    w_stall_n = 1'b0;
    w_ovf_n   = r_ovf;
    w_unf_n   = r_unf;
    w_push    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (intReq) begin
          w_state_n = S_SAVE;
          w_ack_n   = 1'b1;
          w_stall_n = 1'b1;
          if (w_full) begin
            w_ovf_n = 1'b1;
          end else begin
            w_push  = 1'b1;
            w_ptr_n = r_ptr + 1'b1;
          end
        end else if (rtiReq) begin
          if (r_ptr != '0) begin
            w_state_n = S_RESTORE;
            w_ptr_n   = r_ptr - 1'b1;
            w_ss_n    = r_stack[w_rd_idx];
            w_upd_n   = 1'b1;
            w_cf_n    = 2'b10;
            w_stall_n = 1'b1;
          end else begin
            w_unf_n = 1'b1;
          end
        end else if (aluUpdate) begin
          w_upd_n = 1'b1;
          w_cf_n  = 2'b00;
          w_ns_n  = aluFlags;
        end else if (setc) begin
          w_upd_n = 1'b1;
          w_cf_n  = 2'b11;
        end else if (clrc) begin
          w_upd_n = 1'b1;
          w_cf_n  = 2'b01;
        end
      end
      S_SAVE: begin
        w_state_n = S_FLUSH;
        w_cnt_n   = 3'(FLUSH_CYCLES - 1);
        w_stall_n = 1'b1;
      end
      S_FLUSH: begin
        if (r_cnt == 3'd0) begin
          w_state_n = S_IDLE;
        end else begin
          w_cnt_n   = r_cnt - 3'd1;
          w_stall_n = 1'b1;
        end
      end
      S_RESTORE: begin
        w_state_n = S_IDLE;
      end
      default: w_state_n = S_IDLE;
    endcase
    w_busy_n = (w_state_n != S_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_cnt   <= '0;
      r_upd   <= 1'b0;
      r_cf    <= 2'b00;
      r_ns    <= 4'b1000;
      r_ss    <= 4'b1000;
      r_ack   <= 1'b0;
      r_stall <= 1'b0;
      r_busy  <= 1'b0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
      for (int i = 0; i < DEPTH; i++)
        r_stack[i] <= '0;
    end else begin
      r_state <= w_state_n;
      r_ptr   <= w_ptr_n;
      r_cnt   <= w_cnt_n;
      r_upd   <= w_upd_n;
      r_cf    <= w_cf_n;
      r_ns    <= w_ns_n;
      r_ss    <= w_ss_n;
      r_ack   <= w_ack_n;
      r_stall <= w_stall_n;
      r_busy  <= w_busy_n;
      r_ovf   <= w_ovf_n;
      r_unf   <= w_unf_n;
      if (w_push)
        r_stack[w_wr_idx] <= curFlags;
    end
  end

  assign updateStatus   = r_upd;
  assign carryFlag      = r_cf;
  assign newStatus      = r_ns;
  assign savedStatus    = r_ss;
  assign intAck         = r_ack;
  assign stall          = r_stall;
  assign busy           = r_busy;
  assign stackOverflow  = r_ovf;
  assign stackUnderflow = r_unf;

endmodule

// File: tb/tb_flag_context_controller.sv
// Scoreboard bench for flag_context_controller:
// expected outputs queued per driven cycle, popped after the edge.
module tb_flag_context_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic       intReq, rtiReq, aluUpdate, setc, clrc;
  logic [3:0] aluFlags, curFlags;
  logic       updateStatus, intAck, stall, busy;
  logic [1:0] carryFlag;
  logic [3:0] newStatus, savedStatus;
  logic       stackOverflow, stackUnderflow;

  int n_cmp = 0;
  int n_err = 0;
  logic xo = 1'b0;
  logic xu = 1'b0;

  typedef struct {
    string      tag;
    logic       upd;
    logic [1:0] cf;
    logic [3:0] val;
    logic       ack;
    logic       stl;
    logic       bsy;
    logic       ovf;
    logic       unf;
  } exp_t;

  exp_t q[$];

  flag_context_controller #(
    .DEPTH(4), .FLUSH_CYCLES(2)
  ) dut (
    .clk(clk), .reset(reset),
    .intReq(intReq), .rtiReq(rtiReq),
    .aluUpdate(aluUpdate), .aluFlags(aluFlags),
    .setc(setc), .clrc(clrc),
    .curFlags(curFlags),
    .updateStatus(updateStatus),
    .carryFlag(carryFlag),
    .newStatus(newStatus),
    .savedStatus(savedStatus),
    .intAck(intAck), .stall(stall), .busy(busy),
    .stackOverflow(stackOverflow),
    .stackUnderflow(stackUnderflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [7:0] obs,
                     input logic [7:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic step(
    input string      tag,
    input logic       ir, rr, au,
    input logic [3:0] af,
    input logic       sc, cc,
    input logic [3:0] cur,
    input logic       e_upd,
    input logic [1:0] e_cf,
    input logic [3:0] e_val,
    input logic       e_ack, e_stl, e_bsy);
    exp_t e;
    intReq    = ir;
    rtiReq    = rr;
    aluUpdate = au;
    aluFlags  = af;
    setc      = sc;
    clrc      = cc;
    curFlags  = cur;
    e.tag = tag;
    e.upd = e_upd;
    e.cf  = e_cf;
    e.val = e_val;
    e.ack = e_ack;
    e.stl = e_stl;
    e.bsy = e_bsy;
    e.ovf = xo;
    e.unf = xu;
    q.push_back(e);
    @(posedge clk);
    #1;
    e = q.pop_front();
    chk({e.tag, ".upd"}, 8'(updateStatus), 8'(e.upd));
    chk({e.tag, ".ack"}, 8'(intAck), 8'(e.ack));
    chk({e.tag, ".stall"}, 8'(stall), 8'(e.stl));
    chk({e.tag, ".busy"}, 8'(busy), 8'(e.bsy));
    chk({e.tag, ".ovf"}, 8'(stackOverflow), 8'(e.ovf));
    chk({e.tag, ".unf"}, 8'(stackUnderflow), 8'(e.unf));
    if (e.upd)
      chk({e.tag, ".cf"}, 8'(carryFlag), 8'(e.cf));
    if (e.upd && e.cf == 2'b00)
      chk({e.tag, ".ns"}, 8'(newStatus), 8'(e.val));
    if (e.upd && e.cf == 2'b10)
      chk({e.tag, ".ss"}, 8'(savedStatus), 8'(e.val));
  endtask

  task automatic idle(input string tag);
    step(tag, 0, 0, 0, 4'h0, 0, 0, 4'h0,
         0, 2'b00, 4'h0, 0, 0, 0);
  endtask

  // Interrupt entry: SAVE then FLUSH_CYCLES flush cycles, noise ignored.
  task automatic int_seq(input string tag,
                         input logic [3:0] cur);
    step({tag, ".save"}, 1, 0, 0, 4'h0, 0, 0, cur,
         0, 2'b00, 4'h0, 1, 1, 1);
    step({tag, ".fl1"}, 0, 0, 1, 4'h5, 1, 0, 4'h0,
         0, 2'b00, 4'h0, 0, 1, 1);
    step({tag, ".fl2"}, 0, 1, 0, 4'h0, 0, 1, 4'h0,
         0, 2'b00, 4'h0, 0, 1, 1);
    step({tag, ".idle"}, 0, 0, 0, 4'h0, 0, 0, 4'h0,
         0, 2'b00, 4'h0, 0, 0, 0);
  endtask

  task automatic rti_seq(input string tag,
                         input logic [3:0] val);
    step({tag, ".rst"}, 0, 1, 0, 4'h0, 0, 0, 4'h0,
         1, 2'b10, val, 0, 1, 1);
    step({tag, ".end"}, 0, 1, 0, 4'h0, 0, 0, 4'h0,
         0, 2'b00, 4'h0, 0, 0, 0);
  endtask

  initial begin
    reset = 1'b0;
    intReq = 0; rtiReq = 0; aluUpdate = 0;
    setc = 0; clrc = 0;
    aluFlags = 4'h0; curFlags = 4'h0;
    #12;
    chk("rst.upd", 8'(updateStatus), 8'h0);
    chk("rst.cf", 8'(carryFlag), 8'h0);
    chk("rst.ns", 8'(newStatus), 8'h8);
    chk("rst.ss", 8'(savedStatus), 8'h8);
    chk("rst.stall", 8'(stall), 8'h0);
    chk("rst.busy", 8'(busy), 8'h0);
    #10;
    reset = 1'b1;
    #2;

    step("alu", 0, 0, 1, 4'b1011, 1, 0, 4'h0,
         1, 2'b00, 4'b1011, 0, 0, 0);
    step("setc", 0, 0, 0, 4'h0, 1, 0, 4'h0,
         1, 2'b11, 4'h0, 0, 0, 0);
    step("clrc", 0, 0, 0, 4'h0, 0, 1, 4'h0,
         1, 2'b01, 4'h0, 0, 0, 0);
    idle("none");

    step("int.save", 1, 0, 1, 4'b0110, 0, 0, 4'b1101,
         0, 2'b00, 4'h0, 1, 1, 1);
    step("int.fl1", 0, 0, 1, 4'b0110, 0, 0, 4'h0,
         0, 2'b00, 4'h0, 0, 1, 1);
    step("int.fl2", 0, 1, 0, 4'h0, 1, 0, 4'h0,
         0, 2'b00, 4'h0, 0, 1, 1);
    idle("int.idle");
    chk("int.ns_kept", 8'(newStatus), 8'b1011);
    chk("int.ptr", 8'(dut.r_ptr), 8'd1);

    rti_seq("rti", 4'b1101);
    chk("rti.ptr", 8'(dut.r_ptr), 8'd0);

    int_seq("n1", 4'b1001);
    int_seq("n2", 4'b1010);
    int_seq("n3", 4'b1011);
    int_seq("n4", 4'b1100);
    xo = 1'b1;
    int_seq("n5", 4'b1110);
    chk("n5.ptr", 8'(dut.r_ptr), 8'd4);
    rti_seq("r4", 4'b1100);
    rti_seq("r3", 4'b1011);
    rti_seq("r2", 4'b1010);
    rti_seq("r1", 4'b1001);

    xu = 1'b1;
    step("unf", 0, 1, 0, 4'h0, 0, 0, 4'h0,
         0, 2'b00, 4'h0, 0, 0, 0);

    step("both.save", 1, 1, 0, 4'h0, 0, 0, 4'b0111,
         0, 2'b00, 4'h0, 1, 1, 1);
    step("both.fl1", 0, 1, 0, 4'h0, 0, 0, 4'h0,
         0, 2'b00, 4'h0, 0, 1, 1);
    step("both.fl2", 0, 1, 0, 4'h0, 0, 0, 4'h0,
         0, 2'b00, 4'h0, 0, 1, 1);
    step("both.idle", 0, 1, 0, 4'h0, 0, 0, 4'h0,
         0, 2'b00, 4'h0, 0, 0, 0);
    rti_seq("both.rti", 4'b0111);

    step("mid.save", 1, 0, 0, 4'h0, 0, 0, 4'b0001,
         0, 2'b00, 4'h0, 1, 1, 1);
    step("mid.fl1", 0, 0, 0, 4'h0, 0, 0, 4'h0,
         0, 2'b00, 4'h0, 0, 1, 1);
    #3;
    reset = 1'b0;
    #1;
    chk("mid.stall", 8'(stall), 8'h0);
    chk("mid.busy", 8'(busy), 8'h0);
    chk("mid.ns", 8'(newStatus), 8'h8);
    chk("mid.ovf", 8'(stackOverflow), 8'h0);
    chk("mid.unf", 8'(stackUnderflow), 8'h0);
    chk("mid.ptr", 8'(dut.r_ptr), 8'd0);
    @(posedge clk);
    #1;
    chk("mid.busy2", 8'(busy), 8'h0);
    chk("mid.stall2", 8'(stall), 8'h0);
    reset = 1'b1;
    xo = 1'b0;
    xu = 1'b0;
    step("post.alu", 0, 0, 1, 4'b0010, 0, 0, 4'h0,
         1, 2'b00, 4'b0010, 0, 0, 0);
    xu = 1'b1;
    step("post.unf", 0, 1, 0, 4'h0, 0, 0, 4'h0,
         0, 2'b00, 4'h0, 0, 0, 0);
    idle("post.idle");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
